// File: rtl/mcu_seq_pkg.sv
// Shared definitions for the MCU sequencer: opcode codes, ALU selector codes, flag bit indices, FSM states.
// The IRQ state only exists when MCU_SEQ_IRQ_EN is defined.
package mcu_seq_pkg;

  localparam int unsigned MCU_LOAD   = 32'd0;
  localparam int unsigned MCU_STORE  = 32'd1;
  localparam int unsigned MCU_LOADI  = 32'd2;
  localparam int unsigned MCU_STOREI = 32'd3;
  localparam int unsigned MCU_ADD    = 32'd4;
  localparam int unsigned MCU_ADDI   = 32'd5;
  localparam int unsigned MCU_ADDC   = 32'd6;
  localparam int unsigned MCU_ADDCI  = 32'd7;
  localparam int unsigned MCU_SUB    = 32'd8;
  localparam int unsigned MCU_SUBI   = 32'd9;
  localparam int unsigned MCU_SUBC   = 32'd10;
  localparam int unsigned MCU_SUBCI  = 32'd11;
  localparam int unsigned MCU_NAND   = 32'd12;
  localparam int unsigned MCU_NANDI  = 32'd13;
  localparam int unsigned MCU_NOR    = 32'd14;
  localparam int unsigned MCU_NORI   = 32'd15;
  localparam int unsigned MCU_XOR    = 32'd16;
  localparam int unsigned MCU_XORI   = 32'd17;
  localparam int unsigned MCU_XNOR   = 32'd18;
  localparam int unsigned MCU_XNORI  = 32'd19;
  localparam int unsigned MCU_JUMP   = 32'd20;
  localparam int unsigned MCU_JZ     = 32'd21;
  localparam int unsigned MCU_JC     = 32'd22;
  localparam int unsigned MCU_JN     = 32'd23;
  localparam int unsigned MCU_NOP    = 32'd24;
  localparam int unsigned MCU_HALT   = 32'd25;

  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_ADDC = 4'd2;
  localparam logic [3:0] ALU_SUB  = 4'd3;
  localparam logic [3:0] ALU_SUBC = 4'd4;
  localparam logic [3:0] ALU_NAND = 4'd5;
  localparam logic [3:0] ALU_NOR  = 4'd6;
  localparam logic [3:0] ALU_XOR  = 4'd7;
  localparam logic [3:0] ALU_XNOR = 4'd8;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_NEG   = 2;

  typedef enum logic [2:0] {
    ST_RESET   = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_MEMWAIT = 3'd3,
    ST_EXECUTE = 3'd4,
    ST_HALT    = 3'd5
`ifdef MCU_SEQ_IRQ_EN
    , ST_IRQ   = 3'd6
`endif
  } state_e;

  function automatic logic is_mem_op(input logic [31:0] op);
    return (op == MCU_LOAD) || (op == MCU_STORE) || (op == MCU_LOADI) || (op == MCU_STOREI);
  endfunction

  function automatic logic is_store_op(input logic [31:0] op);
    return (op == MCU_STORE) || (op == MCU_STOREI);
  endfunction

  function automatic logic [3:0] alu_sel(input logic [31:0] op);
    case (op)
      MCU_ADD,  MCU_ADDI:  return ALU_ADD;
      MCU_ADDC, MCU_ADDCI: return ALU_ADDC;
      MCU_SUB,  MCU_SUBI:  return ALU_SUB;
      MCU_SUBC, MCU_SUBCI: return ALU_SUBC;
      MCU_NAND, MCU_NANDI: return ALU_NAND;
      MCU_NOR,  MCU_NORI:  return ALU_NOR;
      MCU_XOR,  MCU_XORI:  return ALU_XOR;
      MCU_XNOR, MCU_XNORI: return ALU_XNOR;
      default:             return ALU_NOP;
    endcase
  endfunction

  function automatic logic branch_taken(input logic [31:0] op, input logic zero,
                                        input logic carry, input logic neg);
    case (op)
      MCU_JUMP: return 1'b1;
      MCU_JZ:   return zero;
      MCU_JC:   return carry;
      MCU_JN:   return neg;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mcu_seq_wait_cnt.sv
// 4-bit RAM wait counter: loads a start value, counts down to zero and saturates there.
module mcu_wait_cnt
  import mcu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       dec_i,
  input  logic [3:0] load_val_i,
  output logic       zero_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/mcu_seq.sv
// MCU control sequencer: RESET/FETCH/DECODE/[MEMWAIT]/EXECUTE loop with HALT, driving datapath enables.
// Defining MCU_SEQ_IRQ_EN adds the irq/irq_ack/pc_vector ports and the IRQ state after EXECUTE.
module mcu_seq
  import mcu_seq_pkg::*;
#(
  parameter int INST_WIDTH  = 5,
  parameter int APSR_WIDTH  = 3,
  parameter int ALUOP_WIDTH = 4,
  parameter int MEM_WAIT    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic [INST_WIDTH-1:0]  imem_data,
  input  logic [APSR_WIDTH-1:0]  apsr,
  output logic                   ram_write,
  output logic                   imm_update,
  output logic                   pc_count,
  output logic                   pc_load,
  output logic                   psr_update,
  output logic                   opcode_update,
  output logic                   acc_update,
  output logic [ALUOP_WIDTH-1:0] alu_operation,
  output logic                   halted,
  output logic                   busy
`ifdef MCU_SEQ_IRQ_EN
  ,
  input  logic                   irq,
  output logic                   irq_ack,
  output logic                   pc_vector
`endif
);

  localparam logic [3:0] WAIT_LOAD = (MEM_WAIT > 0) ? 4'(MEM_WAIT - 1) : 4'd0;

  state_e                state_q, state_d;
  logic [INST_WIDTH-1:0] opcode_q, opcode_d;
  logic [APSR_WIDTH-1:0] psr_q, psr_d;
  logic [31:0]           op_ext;
  logic [3:0]            alu_code;
  logic                  wait_load, wait_dec, wait_zero;

  assign op_ext = 32'(opcode_q);

  mcu_wait_cnt u_wait_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (wait_load),
    .dec_i      (wait_dec),
    .load_val_i (WAIT_LOAD),
    .zero_o     (wait_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RESET;
      opcode_q <= INST_WIDTH'(MCU_LOAD);
      psr_q    <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      psr_q    <= psr_d;
    end
  end

  // Opcode and flags are captured together so DECODE sees a consistent pair.
  always_comb begin
    opcode_d = opcode_q;
    psr_d    = psr_q;
    if (opcode_update) begin
      opcode_d = imem_data;
      psr_d    = apsr;
    end
  end

  always_comb begin
    state_d       = state_q;
    ram_write     = 1'b0;
    imm_update    = 1'b0;
    pc_count      = 1'b0;
    pc_load       = 1'b0;
    psr_update    = 1'b0;
    opcode_update = 1'b0;
    acc_update    = 1'b0;
    halted        = 1'b0;
    busy          = 1'b0;
    alu_code      = ALU_NOP;
    wait_load     = 1'b0;
    wait_dec      = 1'b0;
`ifdef MCU_SEQ_IRQ_EN
    irq_ack       = 1'b0;
    pc_vector     = 1'b0;
`endif
    case (state_q)
      ST_FETCH: begin
        imm_update = 1'b1;
        pc_count   = 1'b1;
        state_d    = ST_DECODE;
      end
      ST_DECODE: begin
        pc_count  = 1'b1;
        ram_write = is_store_op(op_ext);
        alu_code  = alu_sel(op_ext);
        pc_load   = branch_taken(op_ext, psr_q[FLAG_ZERO], psr_q[FLAG_CARRY], psr_q[FLAG_NEG]);
        if (op_ext == MCU_HALT) begin
          state_d = ST_HALT;
        end else if (is_mem_op(op_ext) && (MEM_WAIT > 0)) begin
          wait_load = 1'b1;
          state_d   = ST_MEMWAIT;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      // Opcode is frozen here, so re-deriving ram_write reproduces the DECODE value.
      ST_MEMWAIT: begin
        busy      = 1'b1;
        ram_write = is_store_op(op_ext);
        wait_dec  = 1'b1;
        if (wait_zero) begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        opcode_update = 1'b1;
        psr_update    = 1'b1;
        acc_update    = 1'b1;
`ifdef MCU_SEQ_IRQ_EN
        state_d       = irq ? ST_IRQ : ST_FETCH;
`else
        state_d       = ST_FETCH;
`endif
      end
      ST_HALT: begin
        halted = 1'b1;
        if (run) begin
          state_d = ST_FETCH;
        end
      end
`ifdef MCU_SEQ_IRQ_EN
      ST_IRQ: begin
        irq_ack   = 1'b1;
        pc_vector = 1'b1;
        state_d   = ST_FETCH;
      end
`endif
      // RESET and any unused encoding.
      default: begin
        opcode_update = 1'b1;
        psr_update    = 1'b1;
        acc_update    = 1'b1;
        state_d       = ST_FETCH;
      end
    endcase
  end

  assign alu_operation = ALUOP_WIDTH'(alu_code);

endmodule
